eth_rx_noc_in_mux: RTL and testbench

Parametrised N-source NoC-to-MAC-RX deframer. It arbitrates round-robin at message granularity among NUM_SRCS NoC input channels and strips each message's header flit. Data flits are forwarded to the RX MAC-side stream with frame size, last and padbytes sideband. Adds header sanity checking: malformed messages are consumed and dropped, not forwarded. It sits between the NoC router ports and the eth RX pipeline, as the next generation of the single-source header-strip block.

---
 rtl/eth_rx_noc_in_mux.sv | 208 ++++++++++++++++++++
 tb/tb_eth_rx_noc_in_mux.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_noc_in_mux.sv
// eth_rx_noc_in_mux
//
// N-source NoC-to-MAC-RX deframer. Arbitrates round-robin, one whole message
// at a time, among NUM_SRCS NoC input channels. Each message starts with a
// header flit carrying msg_len (flit count) and frame_size (bytes). The header
// is stripped and the data flits go to the MAC-side stream with frame size,
// last and padbytes sideband. A header whose msg_len does not match
// ceil(frame_size/BYTES) is rejected: hdr_err pulses and the message body is
// consumed and dropped. A zero msg_len is rejected and has no body.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   noc_in_val/_data  per-source flit valid and data (source i at [i*DATA_W +: DATA_W])
//   noc_in_rdy        per-source ready
//   dst_val/_data     data flit toward the MAC path
//   dst_frame_size    frame size in bytes of the current message
//   dst_last          final flit of the frame
//   dst_padbytes      invalid bytes in the final flit
//   dst_src           index of the granted source
//   dst_rdy           downstream ready
//   hdr_err           one-cycle pulse when a header is rejected
//
// Optional build macro ETH_RX_NOC_IN_MUX_STATS_EN adds saturating 32-bit
// counters stat_frames (forwarded frames) and stat_drops (rejected headers).

module eth_rx_noc_in_mux #(
    parameter int NUM_SRCS       = 2,
    parameter int DATA_W         = 512,
    parameter int MTU_W          = 14,
    parameter int MSG_LEN_W      = 8,
    parameter int MSG_LEN_LSB    = 0,
    parameter int FRAME_SIZE_LSB = 32,
    localparam int BYTES         = DATA_W / 8,
    localparam int PAD_W         = $clog2(BYTES),
    localparam int SRC_W         = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRCS-1:0]        noc_in_val,
    input  logic [NUM_SRCS*DATA_W-1:0] noc_in_data,
    output logic [NUM_SRCS-1:0]        noc_in_rdy,
    output logic                       dst_val,
    output logic [DATA_W-1:0]          dst_data,
    output logic [MTU_W-1:0]           dst_frame_size,
    output logic                       dst_last,
    output logic [PAD_W-1:0]           dst_padbytes,
    output logic [SRC_W-1:0]           dst_src,
    input  logic                       dst_rdy,
    output logic                       hdr_err
`ifdef ETH_RX_NOC_IN_MUX_STATS_EN
    ,
    output logic [31:0]                stat_frames,
    output logic [31:0]                stat_drops
`endif
);

    // Common width for comparing msg_len against the expected flit count.
    localparam int CMP_W = (MSG_LEN_W > MTU_W + 1) ? MSG_LEN_W : MTU_W + 1;

    typedef enum logic [1:0] {S_HDR, S_DATA, S_DRAIN} state_t;

    state_t               state, state_nxt;
    logic [SRC_W-1:0]     rr_ptr, src_q, gnt_idx;
    logic                 gnt_found;
    logic [MSG_LEN_W-1:0] msg_len_q, flit_cnt;
    logic [MTU_W-1:0]     frame_size_q;
    logic [PAD_W-1:0]     pad_q;
    logic                 hdr_err_q;

    logic [DATA_W-1:0]    src_data [NUM_SRCS];
    logic [MSG_LEN_W-1:0] hdr_msg_len;
    logic [MTU_W-1:0]     hdr_frame_size;
    logic [CMP_W-1:0]     hdr_exp;
    logic                 hdr_zero, hdr_good;
    logic [PAD_W-1:0]     hdr_pad;
    logic                 src_val, last_flit;

    for (genvar i = 0; i < NUM_SRCS; i++) begin : g_unpack
        assign src_data[i] = noc_in_data[i*DATA_W +: DATA_W];
    end

    // (base + off) mod NUM_SRCS, for off < NUM_SRCS.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
        logic [SRC_W:0] sum;
        sum = {1'b0, base} + (SRC_W+1)'(off);
        if (sum >= (SRC_W+1)'(NUM_SRCS))
            sum = sum - (SRC_W+1)'(NUM_SRCS);
        return sum[SRC_W-1:0];
    endfunction

    // First valid source at or after rr_ptr, searching upward with wrap.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_SRCS; k++) begin
            if (!gnt_found && noc_in_val[wrap_add(rr_ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    // Header decode of the granted source.
    assign hdr_msg_len    = src_data[gnt_idx][MSG_LEN_LSB +: MSG_LEN_W];
    assign hdr_frame_size = src_data[gnt_idx][FRAME_SIZE_LSB +: MTU_W];
    assign hdr_exp        = (CMP_W'(hdr_frame_size) + CMP_W'(BYTES - 1)) >> PAD_W;
    assign hdr_zero       = (hdr_msg_len == '0);
    assign hdr_good       = !hdr_zero && (CMP_W'(hdr_msg_len) == hdr_exp);
    // Subtraction is modulo BYTES, so a zero remainder yields zero padding.
    assign hdr_pad        = '0 - hdr_frame_size[PAD_W-1:0];

    assign src_val   = noc_in_val[src_q];
    assign last_flit = (flit_cnt == msg_len_q - 1'b1);

    always_comb begin
        state_nxt  = state;
        noc_in_rdy = '0;
        dst_val    = 1'b0;
        dst_last   = 1'b0;
        dst_data   = '0;
        case (state)
            S_HDR: begin
                if (gnt_found) begin
                    noc_in_rdy[gnt_idx] = 1'b1;
                    if (hdr_good)
                        state_nxt = S_DATA;
                    else if (!hdr_zero)
                        state_nxt = S_DRAIN;
                end
            end
            S_DATA: begin
                dst_val            = src_val;
                dst_data           = src_data[src_q];
                dst_last           = last_flit;
                noc_in_rdy[src_q]  = dst_rdy;
                if (src_val && dst_rdy && last_flit)
                    state_nxt = S_HDR;
            end
            S_DRAIN: begin
                noc_in_rdy[src_q] = 1'b1;
                if (src_val && last_flit)
                    state_nxt = S_HDR;
            end
            default: state_nxt = S_HDR;
        endcase
        // Nothing is consumed or offered while reset is held.
        if (rst) begin
            noc_in_rdy = '0;
            dst_val    = 1'b0;
            dst_last   = 1'b0;
            dst_data   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register update in this block order-independent.
            state        <= S_HDR;
            rr_ptr       <= '0;
            src_q        <= '0;
            msg_len_q    <= '0;
            frame_size_q <= '0;
            pad_q        <= '0;
            flit_cnt     <= '0;
            hdr_err_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hdr_err_q <= 1'b0;
            case (state)
                S_HDR: begin
                    if (gnt_found) begin
                        src_q        <= gnt_idx;
                        msg_len_q    <= hdr_msg_len;
                        frame_size_q <= hdr_frame_size;
                        pad_q        <= hdr_pad;
                        flit_cnt     <= '0;
                        rr_ptr       <= wrap_add(gnt_idx, 1);
                        hdr_err_q    <= !hdr_good;
                    end
                end
                S_DATA:  if (src_val && dst_rdy) flit_cnt <= flit_cnt + 1'b1;
                S_DRAIN: if (src_val)            flit_cnt <= flit_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign dst_frame_size = frame_size_q;
    assign dst_padbytes   = pad_q;
    assign dst_src        = src_q;
    assign hdr_err        = hdr_err_q;

`ifdef ETH_RX_NOC_IN_MUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames <= '0;
            stat_drops  <= '0;
        end else begin
            if (state == S_DATA && src_val && dst_rdy && last_flit && stat_frames != '1)
                stat_frames <= stat_frames + 1'b1;
            if (hdr_err_q && stat_drops != '1)
                stat_drops <= stat_drops + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_noc_in_mux.sv
// tb_eth_rx_noc_in_mux
//
// Self-checking bench for eth_rx_noc_in_mux. Each source is fed from a flit
// queue; a message-level reference model decides, every cycle, which source
// should be ready, whether a data beat is offered and what its sideband must
// be. Directed message vectors come from a table; a few hand-written sequences
// cover round-robin fairness, backpressure and reset mid-message; a random
// phase mixes good, mismatched and zero-length headers with random gaps.

module tb_eth_rx_noc_in_mux;

    localparam int NUM_SRCS       = 2;
    localparam int DATA_W         = 512;
    localparam int MTU_W          = 14;
    localparam int MSG_LEN_W      = 8;
    localparam int MSG_LEN_LSB    = 0;
    localparam int FRAME_SIZE_LSB = 32;
    localparam int BYTES          = DATA_W / 8;
    localparam int PAD_W          = $clog2(BYTES);
    localparam int SRC_W          = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_SRCS-1:0]        noc_in_val;
    logic [NUM_SRCS*DATA_W-1:0] noc_in_data;
    logic [NUM_SRCS-1:0]        noc_in_rdy;
    logic                       dst_val;
    logic [DATA_W-1:0]          dst_data;
    logic [MTU_W-1:0]           dst_frame_size;
    logic                       dst_last;
    logic [PAD_W-1:0]           dst_padbytes;
    logic [SRC_W-1:0]           dst_src;
    logic                       dst_rdy;
    logic                       hdr_err;
`ifdef ETH_RX_NOC_IN_MUX_STATS_EN
    logic [31:0]                stat_frames, stat_drops;
`endif

    eth_rx_noc_in_mux #(
        .NUM_SRCS(NUM_SRCS), .DATA_W(DATA_W), .MTU_W(MTU_W), .MSG_LEN_W(MSG_LEN_W),
        .MSG_LEN_LSB(MSG_LEN_LSB), .FRAME_SIZE_LSB(FRAME_SIZE_LSB)
    ) dut (
        .clk(clk), .rst(rst),
        .noc_in_val(noc_in_val), .noc_in_data(noc_in_data), .noc_in_rdy(noc_in_rdy),
        .dst_val(dst_val), .dst_data(dst_data), .dst_frame_size(dst_frame_size),
        .dst_last(dst_last), .dst_padbytes(dst_padbytes), .dst_src(dst_src),
        .dst_rdy(dst_rdy), .hdr_err(hdr_err)
`ifdef ETH_RX_NOC_IN_MUX_STATS_EN
        , .stat_frames(stat_frames), .stat_drops(stat_drops)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Upstream flit queues (header followed by body flits).
    logic [DATA_W-1:0] fq [NUM_SRCS][$];
    bit rand_valid = 1'b0;
    int cyc = 0;

    // Reference model state: message-level view.
    bit m_busy, m_fwd, m_err_next;
    int m_ptr, m_src, m_left, m_fs, m_pad;
    int m_frames, m_drops;
    // Observations from the DUT.
    int beats = 0, errs = 0, last_pad = 0;
    int gl[$];  // DUT grant order (source whose header was consumed)

    function automatic logic [DATA_W-1:0] rand_flit();
        logic [DATA_W-1:0] f;
        for (int i = 0; i < DATA_W / 32; i++) f[i*32 +: 32] = $urandom();
        return f;
    endfunction

    task automatic push_msg(input int s, input int ml, input int fs, input int nfl);
        logic [DATA_W-1:0] f;
        f = rand_flit();
        f[MSG_LEN_LSB +: MSG_LEN_W]  = MSG_LEN_W'(ml);
        f[FRAME_SIZE_LSB +: MTU_W]   = MTU_W'(fs);
        fq[s].push_back(f);
        for (int i = 0; i < nfl; i++) fq[s].push_back(rand_flit());
    endtask

    function automatic bit queues_empty();
        for (int s = 0; s < NUM_SRCS; s++) if (fq[s].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock cycle: drive, predict and compare at negedge, pop on handshakes.
    task automatic run_cycle(input bit rdy_in);
        logic [NUM_SRCS-1:0] exp_rdy;
        logic                exp_val;
        logic [DATA_W-1:0]   hdr;
        bit                  en;
        int                  g, ml, fs, ex;
        dst_rdy = rdy_in;
        for (int s = 0; s < NUM_SRCS; s++) begin
            en = !rand_valid || ($urandom_range(0, 3) != 0);
            noc_in_val[s] = (fq[s].size() > 0) && en;
            noc_in_data[s*DATA_W +: DATA_W] = (fq[s].size() > 0) ? fq[s][0] : '0;
        end
        @(negedge clk);
        exp_rdy = '0;
        exp_val = 1'b0;
        check($sformatf("c%0d_hdr_err", cyc), hdr_err, m_err_next);
        if (hdr_err) errs++;
        if (m_err_next) m_drops++;
        m_err_next = 1'b0;
        if (!m_busy) begin
            g = -1;
            for (int k = 0; k < NUM_SRCS; k++)
                if (g < 0 && noc_in_val[(m_ptr + k) % NUM_SRCS]) g = (m_ptr + k) % NUM_SRCS;
            for (int s = 0; s < NUM_SRCS; s++) if (noc_in_rdy[s]) gl.push_back(s);
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                hdr   = fq[g][0];
                ml    = int'(hdr[MSG_LEN_LSB +: MSG_LEN_W]);
                fs    = int'(hdr[FRAME_SIZE_LSB +: MTU_W]);
                ex    = (fs + BYTES - 1) / BYTES;
                m_ptr = (g + 1) % NUM_SRCS;
                m_src = g;
                m_fs  = fs;
                m_pad = (BYTES - fs % BYTES) % BYTES;
                if (ml == 0) begin
                    m_err_next = 1'b1;
                end else begin
                    m_busy     = 1'b1;
                    m_left     = ml;
                    m_fwd      = (ml == ex);
                    m_err_next = !m_fwd;
                end
            end
        end else if (m_fwd) begin
            exp_rdy[m_src] = rdy_in;
            exp_val        = noc_in_val[m_src];
            if (noc_in_val[m_src] && dst_val) begin
                check($sformatf("c%0d_data", cyc),  dst_data, fq[m_src][0]);
                check($sformatf("c%0d_last", cyc),  dst_last, (m_left == 1));
                check($sformatf("c%0d_pad", cyc),   dst_padbytes, m_pad);
                check($sformatf("c%0d_fsize", cyc), dst_frame_size, m_fs);
                check($sformatf("c%0d_src", cyc),   dst_src, m_src);
            end
            if (noc_in_val[m_src] && rdy_in) begin
                beats++;
                last_pad = int'(dst_padbytes);
                m_left--;
                if (m_left == 0) begin m_busy = 1'b0; m_frames++; end
            end
        end else begin
            exp_rdy[m_src] = 1'b1;
            if (noc_in_val[m_src]) begin
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end
        end
        check($sformatf("c%0d_rdy", cyc), noc_in_rdy, exp_rdy);
        check($sformatf("c%0d_val", cyc), dst_val, exp_val);
        for (int s = 0; s < NUM_SRCS; s++)
            if (noc_in_val[s] && noc_in_rdy[s] && fq[s].size() > 0) void'(fq[s].pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((!queues_empty() || m_busy || m_err_next) && n < limit) begin
            run_cycle(1'b1);
            n++;
        end
        n_cmp++;
        if (n >= limit) begin
            n_bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
        end
    endtask

    // Reset with upstream idle, then confirm every output reads zero.
    task automatic do_reset();
        rst = 1'b1;
        dst_rdy = 1'b0;
        noc_in_val = '0;
        noc_in_data = '0;
        for (int s = 0; s < NUM_SRCS; s++) fq[s].delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_rdy", noc_in_rdy, 0);
        check("rst_val", dst_val, 0);
        check("rst_hdr_err", hdr_err, 0);
        check("rst_last", dst_last, 0);
        check("rst_pad", dst_padbytes, 0);
        check("rst_fsize", dst_frame_size, 0);
        check("rst_src", dst_src, 0);
        check("rst_data", dst_data, 0);
`ifdef ETH_RX_NOC_IN_MUX_STATS_EN
        check("rst_stat_frames", stat_frames, 0);
        check("rst_stat_drops", stat_drops, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 1'b0; m_fwd = 1'b0; m_err_next = 1'b0;
        m_ptr = 0; m_frames = 0; m_drops = 0;
    endtask

    typedef struct {
        int src, ml, fs, nfl;
        int exp_beats, exp_err, exp_pad;
    } vec_t;

    vec_t vecs [10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, e0, g0, ml, fs, ex, k, s;
        vecs[0] = '{0, 2, 100, 2, 2, 0, 28};   // basic two-flit frame
        vecs[1] = '{1, 2, 128, 2, 2, 0, 0};    // exact multiple, no padding
        vecs[2] = '{0, 3, 64,  3, 0, 1, 0};    // msg_len mismatch, drained
        vecs[3] = '{1, 0, 50,  0, 0, 1, 0};    // zero msg_len, no body
        vecs[4] = '{0, 1, 64,  1, 1, 0, 0};    // good message right after a drop
        vecs[5] = '{1, 1, 1,   1, 1, 0, 63};   // one valid byte
        vecs[6] = '{0, 4, 200, 4, 4, 0, 56};
        vecs[7] = '{1, 2, 64,  2, 0, 1, 0};    // too many flits for the size
        vecs[8] = '{0, 1, 0,   1, 0, 1, 0};    // zero frame size, nonzero msg_len
        vecs[9] = '{0, 5, 257, 5, 5, 0, 63};

        rst = 1'b1;
        dst_rdy = 1'b0;
        noc_in_val = '0;
        noc_in_data = '0;
        #1;
        do_reset();

        // Table-driven directed messages.
        for (int i = 0; i < 10; i++) begin
            b0 = beats;
            e0 = errs;
            push_msg(vecs[i].src, vecs[i].ml, vecs[i].fs, vecs[i].nfl);
            drain(100);
            check($sformatf("vec%0d_beats", i), beats - b0, vecs[i].exp_beats);
            check($sformatf("vec%0d_err", i), errs - e0, vecs[i].exp_err);
            if (vecs[i].exp_beats > 0)
                check($sformatf("vec%0d_pad", i), last_pad, vecs[i].exp_pad);
        end

        // Both sources continuously valid with 1-flit messages: grants alternate.
        g0 = gl.size();
        for (int i = 0; i < 3; i++) begin
            push_msg(0, 1, 64, 1);
            push_msg(1, 1, 64, 1);
        end
        drain(100);
        check("rr_count", gl.size() - g0, 6);
        for (int j = g0 + 1; j < gl.size(); j++)
            check($sformatf("rr_alt%0d", j - g0), gl[j], (gl[j-1] + 1) % NUM_SRCS);

        // Backpressure: dst_rdy toggles 1,0,1,... across a two-flit frame.
        b0 = beats;
        push_msg(1, 2, 128, 2);
        k = 0;
        while ((!queues_empty() || m_busy) && k < 50) begin
            run_cycle(k % 2 == 0);
            k++;
        end
        check("toggle_beats", beats - b0, 2);
        check("toggle_pad", last_pad, 0);

        // Zero msg_len immediately followed by a good header on the same source.
        b0 = beats;
        e0 = errs;
        push_msg(0, 0, 10, 0);
        push_msg(0, 1, 10, 1);
        drain(50);
        check("zero_then_good_err", errs - e0, 1);
        check("zero_then_good_beats", beats - b0, 1);
        check("zero_then_good_pad", last_pad, 54);

        // Reset in the middle of a forwarded message from source 0.
        push_msg(0, 4, 250, 4);
        run_cycle(1'b1);
        run_cycle(1'b1);
        check("mid_msg_val", dst_val, 1);
        do_reset();
        g0 = gl.size();
        push_msg(0, 1, 64, 1);
        push_msg(1, 1, 64, 1);
        drain(50);
        check("post_rst_grant0", gl[g0], 0);
        check("post_rst_grant1", gl[g0 + 1], 1);

        // Random traffic with random valid gaps and downstream backpressure.
        rand_valid = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s  = $urandom_range(0, NUM_SRCS - 1);
                if (fq[s].size() < 20) begin
                    k  = $urandom_range(0, 9);
                    fs = $urandom_range(0, 700);
                    ex = (fs + BYTES - 1) / BYTES;
                    if (k < 7)      ml = ex;
                    else if (k < 9) ml = ex + $urandom_range(1, 2);
                    else            ml = 0;
                    push_msg(s, ml, fs, ml);
                end
            end
            run_cycle($urandom_range(0, 3) != 0);
        end
        rand_valid = 1'b0;
        drain(2000);

`ifdef ETH_RX_NOC_IN_MUX_STATS_EN
        check("stat_frames", stat_frames, m_frames);
        check("stat_drops", stat_drops, m_drops);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
